fog_loop_sequencer: RTL
=======================

Name: fog_loop_sequencer

Overview:
Closed-loop start-up and gain-scheduling controller for the FOG demodulation/feedback chain.
- Sequences the loop through settle, coarse-gain acquisition and fine-gain lock.
- Drives the feedback-enable, step-gain and ramp-gain controls of the step and ramp generators, replacing static CPU values.
- Monitors the demodulated error every step-sync period, declares lock and loss-of-lock, and reports state to the CPU.

Parameters:
ERR_W, 32, error input width (signed)
CNT_W, 16, width of all period counters and count configs
GAIN_W, 32, width of gain-select outputs

Ports:
i_clk  in  1  CPU-domain clock
i_rst  in  1  reset; asynchronous, active-high
i_trig  in  1  one-cycle step-sync pulse, one per modulation period
i_err  in  ERR_W  signed demodulated error, valid when i_trig=1
i_start  in  1  pulse: begin sequence (from IDLE or FAULT)
i_abort  in  1  pulse: return to IDLE from any state
i_settle_cnt  in  CNT_W  periods held open-loop before feedback
i_acq_timeout  in  CNT_W  max COARSE periods before FAULT; 0 = no timeout
i_lock_thresh  in  ERR_W  unsigned |err| window
i_lock_cnt  in  CNT_W  consecutive in-window periods to declare lock
i_unlock_cnt  in  CNT_W  consecutive out-of-window periods to drop lock
i_gain_coarse_step / i_gain_fine_step  in  GAIN_W  step gain per phase
i_gain_coarse_ramp / i_gain_fine_ramp  in  GAIN_W  ramp gain per phase
o_fb_ON  out  32  feedback enable (bit0 meaningful, upper bits 0)
o_gain_sel_step  out  GAIN_W  to step generator
o_gain_sel_ramp  out  GAIN_W  to ramp generator
o_state  out  3  current state encoding
o_locked  out  1  high in LOCK
o_lock_lost  out  1  one-cycle pulse on LOCK->COARSE
o_fault  out  1  high in FAULT

Behaviour:
- Reset, async, i_rst=1: state=IDLE, all counters 0, o_fb_ON=0, gain outputs 0, o_locked=0, o_lock_lost=0, o_fault=0.
- Config latch: all i_* config inputs are captured into shadow registers on the accepted i_start. Config changes mid-sequence have no effect until the next start.
- Window test: |i_err| is computed with saturation; -2^(ERR_W-1) maps to 2^(ERR_W-1)-1. in_win = |err| <= i_lock_thresh. Evaluated only on i_trig.
- State encoding: IDLE=0, SETTLE=1, COARSE=2, LOCK=3, FAULT=4.
- IDLE: fb_ON=0, gains 0. On i_start go to SETTLE and clear the counter.
- SETTLE: fb_ON=0, gains = coarse. Count i_trig. When count reaches settle_cnt, go to COARSE. settle_cnt=0 means COARSE on the first i_trig.
- COARSE: fb_ON=1, gains = coarse.
  - Per i_trig: in_win increments the good counter, otherwise it clears it.
  - The timeout counter increments on every i_trig.
  - good==lock_cnt (lock_cnt=0 treated as 1) -> LOCK.
  - Otherwise timeout counter==acq_timeout with acq_timeout≠0 -> FAULT.
  - Lock wins if both occur on the same i_trig.
- LOCK: fb_ON=1, gains = fine, o_locked=1.
  - Per i_trig: !in_win increments the bad counter, in_win clears it.
  - bad==unlock_cnt (0 treated as 1) -> COARSE, o_lock_lost pulses 1 cycle, and all counters clear.
- FAULT: fb_ON=0, gains 0, o_fault=1. Only i_start (restarts, to SETTLE) or i_abort (to IDLE) leaves FAULT.
- Priority per cycle: i_abort > i_start > i_trig evaluation. i_start in SETTLE/COARSE/LOCK is ignored.
- Latency: state and all outputs are registered and update on the clock edge after the cycle with the deciding i_trig or command pulse.
- Gain and fb_ON change only on state transitions, which land between step-sync pulses, so the step generator never sees a mid-period change.
- Counters saturate at all-ones and never wrap.
- i_trig while IDLE is ignored.

Decomposition:
- Package fog_seq_pkg holds:
  - the state enum (3-bit typedef, values above);
  - the ERR_W/CNT_W defaults;
  - a saturating-abs function.
- One sub-module, fog_err_window: registered saturating |err| compare against the threshold, producing in_win with its i_trig aligned one cycle later.
- The main FSM consumes the delayed trigger; total decision latency is i_trig + 2 cycles, documented in o_state timing.

Test Plan:
1. Reset: assert i_rst mid-LOCK -> next edge-independent outputs all 0, state=0; on release stays IDLE with i_trig toggling.
2. Settle: settle_cnt=4, start, 4 i_trig -> o_fb_ON 0→1 and state 1→2 after 4th trig; gain_sel_step = coarse value 7.
3. Lock: thresh=100, lock_cnt=3, errs 50,-80,200,10,-100,99 -> locked after 6th trig (counter reset by 200); gains switch to fine 3.
4. Unlock: in LOCK with unlock_cnt=2, errs 150,20,-150,-101 -> single o_lock_lost pulse after 4th, state=2, fb_ON stays 1.
5. Timeout/saturation: acq_timeout=5, errs all -2^31 -> FAULT after 5th trig with fb_ON=0; then start -> SETTLE; abort+start same cycle -> IDLE.
6. Config isolation: change lock_cnt during COARSE -> lock timing follows value latched at start.

Source files
------------

// File: rtl/fog_seq_pkg.sv
// Shared types and helpers for the FOG loop start-up / gain-scheduling sequencer.
package fog_seq_pkg;

    localparam int ERR_W_DEF  = 32;
    localparam int CNT_W_DEF  = 16;
    localparam int GAIN_W_DEF = 32;

    // state     | meaning
    // IDLE      | loop open, gains zero, waiting for start
    // SETTLE    | open loop, coarse gains preloaded, counting settle periods
    // COARSE    | feedback on, coarse gains, acquiring lock
    // LOCK      | feedback on, fine gains, watching for loss of lock
    // FAULT     | acquisition timed out, loop open until start or abort
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SETTLE = 3'd1,
        ST_COARSE = 3'd2,
        ST_LOCK   = 3'd3,
        ST_FAULT  = 3'd4
    } seq_state_t;

    // |x| for a w-bit signed value carried sign-extended in 64 bits; the most
    // negative w-bit value folds onto the most positive one.
    function automatic logic [63:0] sat_abs(input logic signed [63:0] x, input int unsigned w);
        logic signed [63:0] most_neg;
        most_neg = -(64'sd1 <<< (w - 1));
        if (x == most_neg) begin
            return (64'd1 << (w - 1)) - 64'd1;
        end
        if (x < 0) begin
            return -x;
        end
        return x;
    endfunction

endpackage

// File: rtl/fog_err_window.sv
// Registered error-window test: in_win is valid in the cycle where trig_q is high,
// one cycle after the step-sync pulse that carried the error sample.
module fog_err_window
    import fog_seq_pkg::*;
#(
    parameter int ERR_W = ERR_W_DEF
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    trig,
    input  logic signed [ERR_W-1:0] err,
    input  logic [ERR_W-1:0]        thresh,
    output logic                    trig_q,
    output logic                    in_win
);

    logic [63:0] err_abs;

    assign err_abs = sat_abs(64'(err), ERR_W);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            trig_q <= 1'b0;
            in_win <= 1'b0;
        end else begin
            trig_q <= trig;
            if (trig) begin
                in_win <= (err_abs <= 64'(thresh));
            end
        end
    end

endmodule

// File: rtl/fog_loop_sequencer.sv
// FOG closed-loop sequencer: settle, coarse acquisition, fine lock and fault handling.
// Step-sync decisions land on o_state two clock edges after the i_trig cycle.
module fog_loop_sequencer
    import fog_seq_pkg::*;
#(
    parameter int ERR_W  = ERR_W_DEF,
    parameter int CNT_W  = CNT_W_DEF,
    parameter int GAIN_W = GAIN_W_DEF
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic                    i_trig,
    input  logic signed [ERR_W-1:0] i_err,
    input  logic                    i_start,
    input  logic                    i_abort,
    input  logic [CNT_W-1:0]        i_settle_cnt,
    input  logic [CNT_W-1:0]        i_acq_timeout,
    input  logic [ERR_W-1:0]        i_lock_thresh,
    input  logic [CNT_W-1:0]        i_lock_cnt,
    input  logic [CNT_W-1:0]        i_unlock_cnt,
    input  logic [GAIN_W-1:0]       i_gain_coarse_step,
    input  logic [GAIN_W-1:0]       i_gain_fine_step,
    input  logic [GAIN_W-1:0]       i_gain_coarse_ramp,
    input  logic [GAIN_W-1:0]       i_gain_fine_ramp,
    output logic [31:0]             o_fb_ON,
    output logic [GAIN_W-1:0]       o_gain_sel_step,
    output logic [GAIN_W-1:0]       o_gain_sel_ramp,
    output logic [2:0]              o_state,
    output logic                    o_locked,
    output logic                    o_lock_lost,
    output logic                    o_fault
);

    seq_state_t         state, state_nxt;
    logic [CNT_W-1:0]   period_cnt, period_nxt;
    logic [CNT_W-1:0]   good_cnt, good_nxt;
    logic [CNT_W-1:0]   bad_cnt, bad_nxt;
    logic               lost_nxt;

    logic [CNT_W-1:0]   settle_q, acq_q, lock_q, unlock_q;
    logic [ERR_W-1:0]   thresh_q;
    logic [GAIN_W-1:0]  cstep_q, cramp_q, fstep_q, framp_q;

    logic               trig_q;
    logic               in_win;
    logic               accept_start;
    logic [CNT_W-1:0]   lock_eff, unlock_eff;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        return (&c) ? c : c + CNT_W'(1);
    endfunction

    fog_err_window #(.ERR_W(ERR_W)) u_win (
        .clk    (i_clk),
        .rst    (i_rst),
        .trig   (i_trig),
        .err    (i_err),
        .thresh (thresh_q),
        .trig_q (trig_q),
        .in_win (in_win)
    );

    assign accept_start = i_start && !i_abort && (state == ST_IDLE || state == ST_FAULT);
    assign lock_eff     = (lock_q == '0) ? CNT_W'(1) : lock_q;
    assign unlock_eff   = (unlock_q == '0) ? CNT_W'(1) : unlock_q;

    always_comb begin
        state_nxt  = state;
        period_nxt = period_cnt;
        good_nxt   = good_cnt;
        bad_nxt    = bad_cnt;
        lost_nxt   = 1'b0;
        if (i_abort) begin
            state_nxt  = ST_IDLE;
            period_nxt = '0;
            good_nxt   = '0;
            bad_nxt    = '0;
        end else if (accept_start) begin
            state_nxt  = ST_SETTLE;
            period_nxt = '0;
            good_nxt   = '0;
            bad_nxt    = '0;
        end else if (trig_q) begin
            case (state)
                ST_SETTLE: begin
                    period_nxt = sat_inc(period_cnt);
                    if (period_nxt >= settle_q) begin
                        state_nxt  = ST_COARSE;
                        period_nxt = '0;
                        good_nxt   = '0;
                        bad_nxt    = '0;
                    end
                end
                ST_COARSE: begin
                    good_nxt   = in_win ? sat_inc(good_cnt) : '0;
                    period_nxt = sat_inc(period_cnt);
                    // Lock takes precedence over a timeout on the same period.
                    if (good_nxt == lock_eff) begin
                        state_nxt = ST_LOCK;
                        bad_nxt   = '0;
                    end else if (acq_q != '0 && period_nxt == acq_q) begin
                        state_nxt = ST_FAULT;
                    end
                end
                ST_LOCK: begin
                    bad_nxt = in_win ? '0 : sat_inc(bad_cnt);
                    if (bad_nxt == unlock_eff) begin
                        state_nxt  = ST_COARSE;
                        lost_nxt   = 1'b1;
                        period_nxt = '0;
                        good_nxt   = '0;
                        bad_nxt    = '0;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state           <= ST_IDLE;
            period_cnt      <= '0;
            good_cnt        <= '0;
            bad_cnt         <= '0;
            settle_q        <= '0;
            acq_q           <= '0;
            lock_q          <= '0;
            unlock_q        <= '0;
            thresh_q        <= '0;
            cstep_q         <= '0;
            cramp_q         <= '0;
            fstep_q         <= '0;
            framp_q         <= '0;
            o_fb_ON         <= '0;
            o_gain_sel_step <= '0;
            o_gain_sel_ramp <= '0;
            o_state         <= 3'd0;
            o_locked        <= 1'b0;
            o_lock_lost     <= 1'b0;
            o_fault         <= 1'b0;
        end else begin
            state       <= state_nxt;
            period_cnt  <= period_nxt;
            good_cnt    <= good_nxt;
            bad_cnt     <= bad_nxt;
            o_state     <= state_nxt;
            o_lock_lost <= lost_nxt;
            o_locked    <= (state_nxt == ST_LOCK);
            o_fault     <= (state_nxt == ST_FAULT);
            o_fb_ON     <= {31'b0, (state_nxt == ST_COARSE || state_nxt == ST_LOCK)};
            if (accept_start) begin
                settle_q <= i_settle_cnt;
                acq_q    <= i_acq_timeout;
                lock_q   <= i_lock_cnt;
                unlock_q <= i_unlock_cnt;
                thresh_q <= i_lock_thresh;
                cstep_q  <= i_gain_coarse_step;
                cramp_q  <= i_gain_coarse_ramp;
                fstep_q  <= i_gain_fine_step;
                framp_q  <= i_gain_fine_ramp;
            end
            // The shadows only load on the start edge, so take the fresh values there.
            case (state_nxt)
                ST_SETTLE, ST_COARSE: begin
                    o_gain_sel_step <= accept_start ? i_gain_coarse_step : cstep_q;
                    o_gain_sel_ramp <= accept_start ? i_gain_coarse_ramp : cramp_q;
                end
                ST_LOCK: begin
                    o_gain_sel_step <= fstep_q;
                    o_gain_sel_ramp <= framp_q;
                end
                default: begin
                    o_gain_sel_step <= '0;
                    o_gain_sel_ramp <= '0;
                end
            endcase
        end
    end

endmodule
